// File: rtl/f2sdram_arb_pkg.sv
// Shared types for the two-requester f2sdram burst arbiter: FSM state and read tag.
package f2sdram_arb_pkg;

  // Width of the burstcount field carried in a read tag; the arbiter's
  // BURSTCOUNT_WIDTH defaults to this value and should be kept equal to it.
  localparam int TAG_BC_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WR_BURST = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                id;
    logic [TAG_BC_W-1:0] burstcount;
  } rd_tag_t;

endpackage

// File: rtl/f2sdram_rd_tag_fifo.sv
// Read tag FIFO: remembers which requester owns each outstanding read burst.
// The head entry is held in a register so the return path sees a clean output.
module f2sdram_rd_tag_fifo
  import f2sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    reset_i,
  input  logic    push_i,
  input  rd_tag_t push_tag_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output rd_tag_t head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  rd_tag_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  rd_tag_t          head_q, head_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign head_o  = head_q;

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || pop_i);

  // Next occupancy and next head entry.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (do_pop) begin
      if (count_q > CNT_ONE) begin
        head_d = mem_q[rd_ptr_q + PTR_ONE];
      end else if (do_push) begin
        head_d = push_tag_i;
      end
    end else if (empty_o && do_push) begin
      head_d = push_tag_i;
    end
  end

  // Tag storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_tag_i;
    end
  end

  // Pointers, occupancy and head register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/f2sdram_burst_arbiter.sv
// Two-requester round-robin Avalon-MM burst arbiter in front of an f2sdram port.
// Commands pass through combinationally once granted; read data is routed back
// using a tag FIFO of outstanding read bursts.
module f2sdram_burst_arbiter
  import f2sdram_arb_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int BURSTCOUNT_WIDTH = TAG_BC_W,
  parameter int RD_TAG_DEPTH     = 4,
  localparam int BYTEENABLE_WIDTH = DATA_WIDTH/8,
  localparam int ADDRESS_WIDTH    = 32 - $clog2(BYTEENABLE_WIDTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  // requester 0
  output logic                        waitrequest_0,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount_0,
  input  logic [ADDRESS_WIDTH-1:0]    address_0,
  output logic [DATA_WIDTH-1:0]       readdata_0,
  output logic                        readdatavalid_0,
  input  logic                        read_0,
  input  logic [DATA_WIDTH-1:0]       writedata_0,
  input  logic [BYTEENABLE_WIDTH-1:0] byteenable_0,
  input  logic                        write_0,
  // requester 1
  output logic                        waitrequest_1,
  input  logic [BURSTCOUNT_WIDTH-1:0] burstcount_1,
  input  logic [ADDRESS_WIDTH-1:0]    address_1,
  output logic [DATA_WIDTH-1:0]       readdata_1,
  output logic                        readdatavalid_1,
  input  logic                        read_1,
  input  logic [DATA_WIDTH-1:0]       writedata_1,
  input  logic [BYTEENABLE_WIDTH-1:0] byteenable_1,
  input  logic                        write_1,
  // master toward f2sdram
  input  logic                        waitrequest_master,
  output logic [BURSTCOUNT_WIDTH-1:0] burstcount_master,
  output logic [ADDRESS_WIDTH-1:0]    address_master,
  input  logic [DATA_WIDTH-1:0]       readdata_master,
  input  logic                        readdatavalid_master,
  output logic                        read_master,
  output logic [DATA_WIDTH-1:0]       writedata_master,
  output logic [BYTEENABLE_WIDTH-1:0] byteenable_master,
  output logic                        write_master,
  output logic                        rd_unexpected
);

  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE = BURSTCOUNT_WIDTH'(1);

  arb_state_e                  state_q;
  logic                        grant_q, prio_q, rd_unexp_q;
  logic [BURSTCOUNT_WIDTH-1:0] beat_cnt_q, burst_len_q, rd_beat_q;

  logic                        g_read, g_write, elig0, elig1, pick, active;
  logic [BURSTCOUNT_WIDTH-1:0] g_bc, head_bc;
  logic [ADDRESS_WIDTH-1:0]    g_addr;
  logic [DATA_WIDTH-1:0]       g_wdata;
  logic [BYTEENABLE_WIDTH-1:0] g_be;
  logic                        fifo_full, fifo_empty, push, pop, rvld_ok;
  rd_tag_t                     push_tag, head_tag;

  // Granted requester's command signals.
  assign g_read  = grant_q ? read_1       : read_0;
  assign g_write = grant_q ? write_1      : write_0;
  assign g_bc    = grant_q ? burstcount_1 : burstcount_0;
  assign g_addr  = grant_q ? address_1    : address_0;
  assign g_wdata = grant_q ? writedata_1  : writedata_0;
  assign g_be    = grant_q ? byteenable_1 : byteenable_0;

  // Reads need a free tag slot; writes never do.
  assign elig0  = write_0 || (read_0 && !fifo_full);
  assign elig1  = write_1 || (read_1 && !fifo_full);
  assign pick   = (elig0 && elig1) ? prio_q : elig1;
  assign active = (state_q != IDLE);

  assign read_master       = active && g_read;
  assign write_master      = active && g_write;
  assign burstcount_master = active ? g_bc    : '0;
  assign address_master    = active ? g_addr  : '0;
  assign writedata_master  = active ? g_wdata : '0;
  assign byteenable_master = active ? g_be    : '0;
  assign waitrequest_0     = (active && !grant_q) ? waitrequest_master : 1'b1;
  assign waitrequest_1     = (active &&  grant_q) ? waitrequest_master : 1'b1;

  assign push              = (state_q == CMD) && g_read && !waitrequest_master;
  assign push_tag.id         = grant_q;
  assign push_tag.burstcount = TAG_BC_W'(g_bc);

  assign head_bc         = BURSTCOUNT_WIDTH'(head_tag.burstcount);
  assign rvld_ok         = readdatavalid_master && !fifo_empty;
  assign pop             = rvld_ok && (rd_beat_q == head_bc - BC_ONE);
  assign readdata_0      = readdata_master;
  assign readdata_1      = readdata_master;
  assign readdatavalid_0 = rvld_ok && !head_tag.id;
  assign readdatavalid_1 = rvld_ok &&  head_tag.id;
  assign rd_unexpected   = rd_unexp_q;

  f2sdram_rd_tag_fifo #(.DEPTH(RD_TAG_DEPTH)) u_fifo (
    .clk_i      (clk),
    .reset_i    (reset),
    .push_i     (push),
    .push_tag_i (push_tag),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_tag)
  );

  // Arbitration FSM: grant in IDLE, forward one command, hold grant for a write burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (elig0 || elig1) begin
            grant_q <= pick;
            state_q <= CMD;
          end
        end
        CMD: begin
          if (g_read && !waitrequest_master) begin
            state_q <= IDLE;
            prio_q  <= ~grant_q;
          end else if (g_write && !waitrequest_master) begin
            if (g_bc == BC_ONE) begin
              state_q <= IDLE;
              prio_q  <= ~grant_q;
            end else begin
              burst_len_q <= g_bc;
              beat_cnt_q  <= BC_ONE;
              state_q     <= WR_BURST;
            end
          end else if (!g_read && !g_write) begin
            state_q <= IDLE;
            prio_q  <= ~grant_q;
          end
        end
        WR_BURST: begin
          if (g_write && !waitrequest_master) begin
            beat_cnt_q <= beat_cnt_q + BC_ONE;
            if (beat_cnt_q == burst_len_q - BC_ONE) begin
              state_q <= IDLE;
              prio_q  <= ~grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read return: count beats of the head burst and flag data with no owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_beat_q  <= '0;
      rd_unexp_q <= 1'b0;
    end else begin
      if (rvld_ok) begin
        rd_beat_q <= pop ? '0 : rd_beat_q + BC_ONE;
      end
      if (readdatavalid_master && fifo_empty) begin
        rd_unexp_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_f2sdram_burst_arbiter.sv
// Directed bench for f2sdram_burst_arbiter: write bursts, read routing,
// tag FIFO full/flow cases, unexpected read data and reset mid-burst.
module tb_f2sdram_burst_arbiter;
  import f2sdram_arb_pkg::*;

  localparam int DW  = 64;
  localparam int BCW = 8;
  localparam int BEW = DW/8;
  localparam int AW  = 32 - $clog2(BEW);

  logic clk, reset;
  logic waitrequest_0, readdatavalid_0, read_0, write_0;
  logic waitrequest_1, readdatavalid_1, read_1, write_1;
  logic [BCW-1:0] burstcount_0, burstcount_1, burstcount_master;
  logic [AW-1:0]  address_0, address_1, address_master;
  logic [DW-1:0]  readdata_0, readdata_1, writedata_0, writedata_1;
  logic [DW-1:0]  readdata_master, writedata_master;
  logic [BEW-1:0] byteenable_0, byteenable_1, byteenable_master;
  logic waitrequest_master, readdatavalid_master, read_master, write_master, rd_unexpected;

  int checks = 0;
  int errors = 0;

  f2sdram_burst_arbiter #(.DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BCW), .RD_TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .waitrequest_0(waitrequest_0), .burstcount_0(burstcount_0), .address_0(address_0),
    .readdata_0(readdata_0), .readdatavalid_0(readdatavalid_0), .read_0(read_0),
    .writedata_0(writedata_0), .byteenable_0(byteenable_0), .write_0(write_0),
    .waitrequest_1(waitrequest_1), .burstcount_1(burstcount_1), .address_1(address_1),
    .readdata_1(readdata_1), .readdatavalid_1(readdatavalid_1), .read_1(read_1),
    .writedata_1(writedata_1), .byteenable_1(byteenable_1), .write_1(write_1),
    .waitrequest_master(waitrequest_master), .burstcount_master(burstcount_master),
    .address_master(address_master), .readdata_master(readdata_master),
    .readdatavalid_master(readdatavalid_master), .read_master(read_master),
    .writedata_master(writedata_master), .byteenable_master(byteenable_master),
    .write_master(write_master), .rd_unexpected(rd_unexpected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    read_0 = 0; write_0 = 0; burstcount_0 = '0; address_0 = '0; writedata_0 = '0; byteenable_0 = '0;
    read_1 = 0; write_1 = 0; burstcount_1 = '0; address_1 = '0; writedata_1 = '0; byteenable_1 = '0;
    waitrequest_master = 0; readdatavalid_master = 0; readdata_master = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    tick();
  endtask

  // Issue a read from one requester and wait (bounded) for it to be accepted.
  task automatic do_read(input bit id, input logic [BCW-1:0] bc, input logic [AW-1:0] addr, output bit ok);
    ok = 0;
    if (id) begin read_1 = 1; burstcount_1 = bc; address_1 = addr; end
    else    begin read_0 = 1; burstcount_0 = bc; address_0 = addr; end
    for (int i = 0; i < 8 && !ok; i++) begin
      #1;
      if ((id ? waitrequest_1 : waitrequest_0) === 1'b0) ok = 1;
      tick();
    end
    if (id) read_1 = 0; else read_0 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    write_0 = 1; burstcount_0 = 8'd4; read_1 = 1; burstcount_1 = 8'd2;
    tick();
    tick();
    #1;
    checks++;
    if (waitrequest_0 !== 1'b1 || waitrequest_1 !== 1'b1)
      $display("FAIL reset_waitreq: got wr0=%b wr1=%b expected 1 1", waitrequest_0, waitrequest_1);
    checks++;
    if (read_master !== 1'b0 || write_master !== 1'b0 || burstcount_master !== 8'd0 ||
        address_master !== '0 || byteenable_master !== '0)
      $display("FAIL reset_master_idle: got rd=%b wr=%b bc=%0d addr=%0h be=%0h expected all 0",
               read_master, write_master, burstcount_master, address_master, byteenable_master);
    checks++;
    if (rd_unexpected !== 1'b0 || dut.u_fifo.count_q !== 0)
      $display("FAIL reset_flags: got rd_unexpected=%b occ=%0d expected 0 0", rd_unexpected, dut.u_fifo.count_q);
    errors += ((waitrequest_0 !== 1'b1 || waitrequest_1 !== 1'b1) ? 1 : 0)
            + ((read_master !== 1'b0 || write_master !== 1'b0 || burstcount_master !== 8'd0 ||
                address_master !== '0 || byteenable_master !== '0) ? 1 : 0)
            + ((rd_unexpected !== 1'b0 || dut.u_fifo.count_q !== 0) ? 1 : 0);
    apply_reset();
  endtask

  task automatic test_wr_burst();
    int stall [4] = '{0, 1, 1, 0};
    int beats = 0;
    apply_reset();
    write_0 = 1; burstcount_0 = 8'd4; address_0 = 29'h100; byteenable_0 = 8'hFF;
    #1;
    checks++;
    if (write_master !== 1'b0 || waitrequest_0 !== 1'b1) begin
      errors++;
      $display("FAIL wr_idle_first: got wr=%b wreq0=%b expected 0 1", write_master, waitrequest_0);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      writedata_0 = 64'hA000 + 64'(b);
      for (int s = 0; s <= stall[b]; s++) begin
        waitrequest_master = (s < stall[b]);
        #1;
        checks++;
        if (write_master !== 1'b1 || writedata_master !== 64'hA000 + 64'(b) ||
            waitrequest_0 !== waitrequest_master || waitrequest_1 !== 1'b1 || burstcount_master !== 8'd4) begin
          errors++;
          $display("FAIL wr_beat%0d: got wr=%b wd=%0h wreq0=%b wreq1=%b bc=%0d expected 1 %0h %b 1 4",
                   b, write_master, writedata_master, waitrequest_0, waitrequest_1, burstcount_master,
                   64'hA000 + 64'(b), waitrequest_master);
        end
        if (write_master === 1'b1 && !waitrequest_master) beats++;
        tick();
      end
    end
    write_0 = 0; waitrequest_master = 0;
    #1;
    checks++;
    if (beats != 4 || dut.state_q !== IDLE || write_master !== 1'b0) begin
      errors++;
      $display("FAIL wr_done: got beats=%0d state=%0d wr=%b expected 4 0 0", beats, dut.state_q, write_master);
    end
    tick();
  endtask

  task automatic test_rd_both();
    bit exp_v0 [4] = '{1, 1, 0, 0};
    apply_reset();
    read_0 = 1; burstcount_0 = 8'd2; address_0 = 29'h0AA;
    read_1 = 1; burstcount_1 = 8'd2; address_1 = 29'h0BB;
    tick();
    #1;
    checks++;
    if (address_master !== 29'h0AA || read_master !== 1'b1 || burstcount_master !== 8'd2 ||
        waitrequest_0 !== 1'b0 || waitrequest_1 !== 1'b1) begin
      errors++;
      $display("FAIL rd_grant_first: got addr=%0h rd=%b bc=%0d wreq0=%b wreq1=%b expected aa 1 2 0 1",
               address_master, read_master, burstcount_master, waitrequest_0, waitrequest_1);
    end
    tick();
    read_0 = 0;
    tick();
    #1;
    checks++;
    if (address_master !== 29'h0BB || waitrequest_1 !== 1'b0 || waitrequest_0 !== 1'b1) begin
      errors++;
      $display("FAIL rd_grant_second: got addr=%0h wreq0=%b wreq1=%b expected bb 1 0",
               address_master, waitrequest_0, waitrequest_1);
    end
    tick();
    read_1 = 0;
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 2) begin
      errors++;
      $display("FAIL rd_occ_two: got %0d expected 2", dut.u_fifo.count_q);
    end
    for (int k = 0; k < 4; k++) begin
      readdata_master = 64'hD00D_0000 + 64'(k);
      readdatavalid_master = 1;
      #1;
      checks++;
      if (readdatavalid_0 !== exp_v0[k] || readdatavalid_1 !== !exp_v0[k] ||
          readdata_0 !== 64'hD00D_0000 + 64'(k) || readdata_1 !== 64'hD00D_0000 + 64'(k)) begin
        errors++;
        $display("FAIL rd_route%0d: got v0=%b v1=%b d0=%0h d1=%0h expected %b %b %0h",
                 k, readdatavalid_0, readdatavalid_1, readdata_0, readdata_1, exp_v0[k], !exp_v0[k],
                 64'hD00D_0000 + 64'(k));
      end
      tick();
    end
    readdatavalid_master = 0;
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 0 || rd_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL rd_drained: got occ=%0d unexp=%b expected 0 0", dut.u_fifo.count_q, rd_unexpected);
    end
    tick();
  endtask

  task automatic test_fifo_full();
    bit ok;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_read(1'b0, 8'd1, AW'(32'h200 + i), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL full_fill%0d: got no accept within 8 cycles expected accept", i);
      end
    end
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 4) begin
      errors++;
      $display("FAIL full_occ: got %0d expected 4", dut.u_fifo.count_q);
    end
    tick();
    read_0 = 1; burstcount_0 = 8'd1; address_0 = 29'h300;
    write_1 = 1; burstcount_1 = 8'd1; address_1 = 29'h400;
    tick();
    #1;
    checks++;
    if (waitrequest_1 !== 1'b0 || write_master !== 1'b1 || read_master !== 1'b0 || waitrequest_0 !== 1'b1) begin
      errors++;
      $display("FAIL full_write_granted: got wreq1=%b wr=%b rd=%b wreq0=%b expected 0 1 0 1",
               waitrequest_1, write_master, read_master, waitrequest_0);
    end
    tick();
    write_1 = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (waitrequest_0 !== 1'b1 || read_master !== 1'b0 || dut.state_q !== IDLE) begin
        errors++;
        $display("FAIL full_read_held%0d: got wreq0=%b rd=%b state=%0d expected 1 0 0",
                 c, waitrequest_0, read_master, dut.state_q);
      end
      tick();
    end
    readdata_master = 64'h1111; readdatavalid_master = 1;
    #1;
    checks++;
    if (readdatavalid_0 !== 1'b1 || readdatavalid_1 !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_route: got v0=%b v1=%b expected 1 0", readdatavalid_0, readdatavalid_1);
    end
    tick();
    readdatavalid_master = 0;
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 3 || waitrequest_0 !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: got occ=%0d wreq0=%b expected 3 1", dut.u_fifo.count_q, waitrequest_0);
    end
    tick();
    #1;
    checks++;
    if (waitrequest_0 !== 1'b0 || read_master !== 1'b1 || address_master !== 29'h300) begin
      errors++;
      $display("FAIL full_read_released: got wreq0=%b rd=%b addr=%0h expected 0 1 300",
               waitrequest_0, read_master, address_master);
    end
    tick();
    read_0 = 0;
    for (int k = 0; k < 4; k++) begin
      readdatavalid_master = 1;
      #1;
      checks++;
      if (readdatavalid_0 !== 1'b1 || readdatavalid_1 !== 1'b0) begin
        errors++;
        $display("FAIL full_drain%0d: got v0=%b v1=%b expected 1 0", k, readdatavalid_0, readdatavalid_1);
      end
      tick();
    end
    readdatavalid_master = 0;
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 0) begin
      errors++;
      $display("FAIL full_drained: got %0d expected 0", dut.u_fifo.count_q);
    end
    tick();
  endtask

  task automatic test_unexpected();
    apply_reset();
    readdata_master = 64'hBAD; readdatavalid_master = 1;
    #1;
    checks++;
    if (readdatavalid_0 !== 1'b0 || readdatavalid_1 !== 1'b0 || rd_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL unexp_dropped: got v0=%b v1=%b flag=%b expected 0 0 0",
               readdatavalid_0, readdatavalid_1, rd_unexpected);
    end
    tick();
    readdatavalid_master = 0;
    tick(); tick(); tick();
    #1;
    checks++;
    if (rd_unexpected !== 1'b1) begin
      errors++;
      $display("FAIL unexp_sticky: got %b expected 1", rd_unexpected);
    end
    reset = 1;
    #1;
    checks++;
    if (rd_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL unexp_reset_clear: got %b expected 0", rd_unexpected);
    end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    apply_reset();
    do_read(1'b0, 8'd2, 29'h050, ok);
    checks++;
    if (!ok || dut.u_fifo.count_q !== 1) begin
      errors++;
      $display("FAIL rst_pre_read: got ok=%b occ=%0d expected 1 1", ok, dut.u_fifo.count_q);
    end
    write_1 = 1; burstcount_1 = 8'd8; address_1 = 29'h600; byteenable_1 = 8'h0F;
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (write_master !== 1'b1 || dut.state_q !== WR_BURST || waitrequest_1 !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_burst: got wr=%b state=%0d wreq1=%b expected 1 2 0",
               write_master, dut.state_q, waitrequest_1);
    end
    reset = 1;
    #1;
    checks++;
    if (write_master !== 1'b0 || read_master !== 1'b0 || burstcount_master !== 8'd0 ||
        address_master !== '0 || byteenable_master !== '0 || waitrequest_0 !== 1'b1 || waitrequest_1 !== 1'b1) begin
      errors++;
      $display("FAIL rst_outputs_idle: got wr=%b rd=%b bc=%0d addr=%0h be=%0h wreq0=%b wreq1=%b expected 0 0 0 0 0 1 1",
               write_master, read_master, burstcount_master, address_master, byteenable_master,
               waitrequest_0, waitrequest_1);
    end
    checks++;
    if (dut.u_fifo.count_q !== 0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL rst_fifo_empty: got occ=%0d state=%0d expected 0 0", dut.u_fifo.count_q, dut.state_q);
    end
    clear_inputs();
    tick();
    reset = 0;
    write_0 = 1; burstcount_0 = 8'd1; address_0 = 29'h700;
    write_1 = 1; burstcount_1 = 8'd1; address_1 = 29'h800;
    tick();
    #1;
    checks++;
    if (waitrequest_0 !== 1'b0 || waitrequest_1 !== 1'b1 || address_master !== 29'h700) begin
      errors++;
      $display("FAIL rst_next_grant: got wreq0=%b wreq1=%b addr=%0h expected 0 1 700",
               waitrequest_0, waitrequest_1, address_master);
    end
    apply_reset();
  endtask

  task automatic test_push_pop_full();
    bit ok;
    bit exp_v1 [4] = '{0, 0, 0, 1};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_read(1'b0, 8'd1, AW'(32'h900 + i), ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pp_fill%0d: got no accept within 8 cycles expected accept", i);
      end
    end
    write_1 = 1; burstcount_1 = 8'd1; address_1 = 29'hA00;
    tick();
    write_1 = 0; read_1 = 1;
    readdata_master = 64'h2222; readdatavalid_master = 1;
    #1;
    checks++;
    if (read_master !== 1'b1 || waitrequest_1 !== 1'b0 || readdatavalid_0 !== 1'b1) begin
      errors++;
      $display("FAIL pp_same_cycle: got rd=%b wreq1=%b v0=%b expected 1 0 1",
               read_master, waitrequest_1, readdatavalid_0);
    end
    tick();
    read_1 = 0; readdatavalid_master = 0;
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 4 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL pp_occ: got occ=%0d state=%0d expected 4 0", dut.u_fifo.count_q, dut.state_q);
    end
    for (int k = 0; k < 4; k++) begin
      readdatavalid_master = 1;
      #1;
      checks++;
      if (readdatavalid_1 !== exp_v1[k] || readdatavalid_0 !== !exp_v1[k]) begin
        errors++;
        $display("FAIL pp_drain%0d: got v0=%b v1=%b expected %b %b",
                 k, readdatavalid_0, readdatavalid_1, !exp_v1[k], exp_v1[k]);
      end
      tick();
    end
    readdatavalid_master = 0;
    #1;
    checks++;
    if (dut.u_fifo.count_q !== 0 || rd_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL pp_drained: got occ=%0d unexp=%b expected 0 0", dut.u_fifo.count_q, rd_unexpected);
    end
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    test_reset();
    test_wr_burst();
    test_rd_both();
    test_fifo_full();
    test_unexpected();
    test_reset_mid_burst();
    test_push_pop_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
